// File: rtl/gzip_axis_byte_serializer_pkg.sv
// Shared widths, FIFO entry layout and tkeep helpers for the gzip byte serializer.
package gzip_axis_byte_serializer_pkg;

    localparam int BYTE_W   = 8;
    localparam int IN_BYTES = 4;
    localparam int WORD_W   = BYTE_W * IN_BYTES;
    localparam int IDX_W    = $clog2(IN_BYTES);
    localparam int CNT_W    = $clog2(IN_BYTES + 1);
    localparam int ENTRY_W  = WORD_W + IN_BYTES + 1;

    typedef struct packed {
        logic                last;
        logic [IN_BYTES-1:0] keep;
        logic [WORD_W-1:0]   data;
    } in_word_t;

    // Number of consecutive kept lanes starting at lane 0.
    function automatic logic [CNT_W-1:0] lead_count(input logic [IN_BYTES-1:0] keep);
        logic [CNT_W-1:0] n;
        logic             run;
        n   = '0;
        run = 1'b1;
        for (int k = 0; k < IN_BYTES; k++) begin
            run = run & keep[k];
            if (run) begin
                n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    // The only tkeep value that is contiguous from lane 0 with n lanes set.
    function automatic logic [IN_BYTES-1:0] lead_mask(input logic [CNT_W-1:0] n);
        logic [IN_BYTES-1:0] m;
        m = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (CNT_W'(k) < n) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gzip_axis_byte_serializer_word_fifo2.sv
// Small synchronous word FIFO with registered ready (not full) and empty flags.
module gzip_axis_byte_serializer_word_fifo2
    import gzip_axis_byte_serializer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               ready,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]        wr_ptr_next, rd_ptr_next;
    logic               ready_reg, empty_reg;
    logic               do_push, do_pop, full_next;

    assign do_push = push & ready_reg;
    assign do_pop  = pop & ~empty_reg;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, do_push};
        rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, do_pop};
        full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ready_reg  <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            ready_reg  <= ~full_next;
            empty_reg  <= (wr_ptr_next == rd_ptr_next);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];
    assign ready   = ready_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/gzip_axis_byte_serializer.sv
// 32-bit AXI-stream to 8-bit AXI-stream serializer, lane 0 first, tlast preserved.
// Optional byte/packet counters are enabled by defining BYTE_SER_STATS_EN.
module gzip_axis_byte_serializer
    import gzip_axis_byte_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                i_tready,
    input  logic                i_tvalid,
    input  logic [WORD_W-1:0]   i_tdata,
    input  logic [IN_BYTES-1:0] i_tkeep,
    input  logic                i_tlast,
    input  logic                o_tready,
    output logic                o_tvalid,
    output logic [BYTE_W-1:0]   o_tdata,
    output logic                o_tlast,
    output logic                o_err
`ifdef BYTE_SER_STATS_EN
    ,
    output logic [31:0]         o_byte_cnt,
    output logic [15:0]         o_pkt_cnt
`endif
);

    in_word_t            in_word, head;
    logic [ENTRY_W-1:0]  head_bits;
    logic                fifo_empty, fifo_pop;
    logic [BYTE_W-1:0]   lanes [IN_BYTES];
    logic [CNT_W-1:0]    run;
    logic                last_lane, out_free, emit, drop, bad_word;

    logic [IDX_W-1:0]    idx_reg;
    logic                o_tvalid_reg, o_tlast_reg, err_reg;
    logic [BYTE_W-1:0]   o_tdata_reg;

    assign in_word = '{last: i_tlast, keep: i_tkeep, data: i_tdata};
    assign head    = head_bits;

    gzip_axis_byte_serializer_word_fifo2 #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (i_tvalid),
        .wr_data (in_word),
        .pop     (fifo_pop),
        .rd_data (head_bits),
        .ready   (i_tready),
        .empty   (fifo_empty)
    );

    generate
        for (genvar gi = 0; gi < IN_BYTES; gi++) begin : g_lane
            assign lanes[gi] = head.data[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Words with lane 0 unkept carry no data and are popped without output.
    always_comb begin
        run       = lead_count(head.keep);
        last_lane = (CNT_W'(idx_reg) + CNT_W'(1)) == run;
        out_free  = ~o_tvalid_reg | o_tready;
        drop      = ~fifo_empty && (run == '0);
        emit      = ~fifo_empty && (run != '0) && out_free;
        fifo_pop  = drop || (emit && last_lane);
        bad_word  = (head.keep != lead_mask(run)) || ((run == '0) && head.last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg      <= '0;
            o_tvalid_reg <= 1'b0;
            o_tdata_reg  <= '0;
            o_tlast_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (fifo_pop) begin
                idx_reg <= '0;
            end else if (emit) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end

            if (emit) begin
                o_tvalid_reg <= 1'b1;
                o_tdata_reg  <= lanes[idx_reg];
                o_tlast_reg  <= last_lane & head.last;
            end else if (o_tready) begin
                o_tvalid_reg <= 1'b0;
            end

            if (fifo_pop && bad_word) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign o_tvalid = o_tvalid_reg;
    assign o_tdata  = o_tdata_reg;
    assign o_tlast  = o_tlast_reg;
    assign o_err    = err_reg;

`ifdef BYTE_SER_STATS_EN
    logic [31:0] byte_cnt_reg;
    logic [15:0] pkt_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg <= '0;
            pkt_cnt_reg  <= '0;
        end else if (o_tvalid_reg && o_tready) begin
            byte_cnt_reg <= byte_cnt_reg + 32'd1;
            if (o_tlast_reg) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
        end
    end

    assign o_byte_cnt = byte_cnt_reg;
    assign o_pkt_cnt  = pkt_cnt_reg;
`endif

endmodule

// File: tb/tb_gzip_axis_byte_serializer.sv
// Self-checking bench: queue-based byte model, per-cycle output compare, directed literal cases.
module tb_gzip_axis_byte_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_tready;
    logic        i_tvalid = 1'b0;
    logic [31:0] i_tdata  = '0;
    logic [3:0]  i_tkeep  = '0;
    logic        i_tlast  = 1'b0;
    logic        o_tready = 1'b1;
    logic        o_tvalid;
    logic [7:0]  o_tdata;
    logic        o_tlast;
    logic        o_err;
`ifdef BYTE_SER_STATS_EN
    logic [31:0] o_byte_cnt;
    logic [15:0] o_pkt_cnt;
`endif

    gzip_axis_byte_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .i_tready (i_tready),
        .i_tvalid (i_tvalid),
        .i_tdata  (i_tdata),
        .i_tkeep  (i_tkeep),
        .i_tlast  (i_tlast),
        .o_tready (o_tready),
        .o_tvalid (o_tvalid),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_err    (o_err)
`ifdef BYTE_SER_STATS_EN
        ,
        .o_byte_cnt (o_byte_cnt),
        .o_pkt_cnt  (o_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rdy_mode = 0;
    int rdy_cnt  = 0;
    int last_accept_edge = 0;

    logic [8:0] exp_q [$];
    logic       exp_err = 1'b0;
    logic [7:0] cap_data [$];
    logic       cap_last [$];
    int         cap_edge [$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Downstream ready: mode 0 always ready, mode p ready one cycle in p.
    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        if (rdy_mode == 0) o_tready = 1'b1;
        else               o_tready = (rdy_cnt % rdy_mode) == 0;
    end

    // Reference: each accepted word contributes its kept lanes up to the first gap.
    task automatic model_push(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        logic [3:0] mask;
        n = 0;
        while (n < 4 && k[n]) n++;
        mask = 4'((1 << n) - 1);
        for (int b = 0; b < n; b++)
            exp_q.push_back({(b == n - 1) && l, d[8*b +: 8]});
        if (k != mask || (n == 0 && l)) exp_err = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("held_valid", {31'd0, o_tvalid}, 32'd1);
                check("held_data", {23'd0, o_tlast, o_tdata}, {23'd0, prev_last, prev_data});
            end
            if (o_tvalid && o_tready) begin
                $display("byte %02h last=%0d edge=%0d", o_tdata, o_tlast, cyc + 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {23'd0, o_tlast, o_tdata}, 32'h1ff);
                end else begin
                    check("byte_stream", {23'd0, o_tlast, o_tdata}, {23'd0, exp_q.pop_front()});
                end
                cap_data.push_back(o_tdata);
                cap_last.push_back(o_tlast);
                cap_edge.push_back(cyc + 1);
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic acc;
        acc = 1'b0;
        i_tdata = d; i_tkeep = k; i_tlast = l; i_tvalid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (i_tready) begin
                model_push(d, k, l);
                last_accept_edge = cyc + 1;
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_cap();
        cap_data.delete(); cap_last.delete(); cap_edge.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        exp_q.delete();
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    logic [7:0] exp6 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    logic [3:0] keep_tab [5] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
    int modes [4] = '{2, 3, 11, 51};

    initial begin
        int first_acc;
        logic [3:0] k;
        logic l;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("rst_tdata", {24'd0, o_tdata}, 32'd0);
        check("rst_tlast", {31'd0, o_tlast}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_itready", {31'd0, i_tready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_itready", {31'd0, i_tready}, 32'd1);
        @(posedge clk); #1;

        // Single full word with tlast
        clear_cap();
        send_word(32'h44332211, 4'hF, 1'b1);
        first_acc = last_accept_edge;
        drain();
        check("t1_count", cap_data.size(), 32'd4);
        if (cap_data.size() == 4) begin
            check("t1_b0", {23'd0, cap_last[0], cap_data[0]}, 32'h011);
            check("t1_b1", {23'd0, cap_last[1], cap_data[1]}, 32'h022);
            check("t1_b2", {23'd0, cap_last[2], cap_data[2]}, 32'h033);
            check("t1_b3", {23'd0, cap_last[3], cap_data[3]}, 32'h144);
            check("t1_latency", cap_edge[0], first_acc + 2);
            check("t1_span", cap_edge[3] - cap_edge[0], 32'd3);
        end
        check("t1_err", {31'd0, o_err}, 32'd0);

        // Two words, second partial: no bubbles across the word boundary
        clear_cap();
        send_word(32'hDDCCBBAA, 4'hF, 1'b0);
        send_word(32'h0000FFEE, 4'h3, 1'b1);
        drain();
        check("t2_count", cap_data.size(), 32'd6);
        if (cap_data.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t2_byte", {23'd0, cap_last[i], cap_data[i]}, {23'd0, i == 5, exp6[i]});
                check("t2_nobubble", cap_edge[i] - cap_edge[0], i);
            end
        end

        // keep=0, last=0: silently dropped
        clear_cap();
        send_word(32'h12345678, 4'h0, 1'b0);
        drain();
        check("drop_count", cap_data.size(), 32'd0);
        check("drop_err", {31'd0, o_err}, 32'd0);

        // Non-contiguous keep: lane 0 only, sticky error
        clear_cap();
        send_word(32'h00990077, 4'b0101, 1'b1);
        drain();
        check("nc_count", cap_data.size(), 32'd1);
        if (cap_data.size() == 1)
            check("nc_byte", {23'd0, cap_last[0], cap_data[0]}, 32'h177);
        check("nc_err", {31'd0, o_err}, 32'd1);
        check("nc_err_model", {31'd0, o_err}, {31'd0, exp_err});

        // Error clears only on reset; keep=0 last=1 then sets it without output
        do_reset();
        check("err_cleared", {31'd0, o_err}, 32'd0);
        clear_cap();
        send_word(32'hCAFEBABE, 4'h0, 1'b1);
        drain();
        check("lost_count", cap_data.size(), 32'd0);
        check("lost_err", {31'd0, o_err}, 32'd1);
        do_reset();

        // Reset after 2 of 4 bytes
        clear_cap();
        send_word(32'h88776655, 4'hF, 1'b1);
        for (int t = 0; t < 100 && cap_data.size() < 2; t++) @(negedge clk);
        check("mid_two_bytes", cap_data.size(), 32'd2);
        @(posedge clk); #3;
        rst = 1'b1;
        exp_q.delete(); exp_err = 1'b0;
        #1;
        check("mid_async_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("mid_async_tdata", {24'd0, o_tdata}, 32'd0);
        check("mid_async_tlast", {31'd0, o_tlast}, 32'd0);
        @(negedge clk);
        check("mid_itready_low", {31'd0, i_tready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_itready_high", {31'd0, i_tready}, 32'd1);
        @(posedge clk); #1;
        clear_cap();
        send_word(32'h000000A5, 4'h1, 1'b1);
        drain();
        check("mid_new_count", cap_data.size(), 32'd1);
        if (cap_data.size() == 1)
            check("mid_new_byte", {23'd0, cap_last[0], cap_data[0]}, 32'h1A5);

        // Random words under each back-pressure pattern
        for (int m = 0; m < 4; m++) begin
            rdy_mode = modes[m];
            for (int w = 0; w < 250; w++) begin
                k = keep_tab[$urandom_range(0, 4)];
                l = (k == 4'h0) ? 1'b0 : 1'($urandom_range(0, 1));
                send_word($urandom, k, l);
                if ($urandom_range(0, 7) == 0) begin
                    @(posedge clk); #1;
                end
            end
            drain();
            check("rand_err", {31'd0, o_err}, 32'd0);
        end
        rdy_mode = 0;

`ifdef BYTE_SER_STATS_EN
        do_reset();
        check("stats_rst_bytes", o_byte_cnt, 32'd0);
        check("stats_rst_pkts", {16'd0, o_pkt_cnt}, 32'd0);
        send_word(32'h04030201, 4'hF, 1'b0);
        send_word(32'h00000005, 4'h1, 1'b1);
        send_word(32'h14131211, 4'hF, 1'b0);
        send_word(32'h18171615, 4'hF, 1'b1);
        send_word(32'h00000021, 4'h1, 1'b1);
        drain();
        check("stats_bytes", o_byte_cnt, 32'd14);
        check("stats_pkts", {16'd0, o_pkt_cnt}, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
